// File: rtl/cabac_pkg.sv
// Shared definitions for the CABAC arithmetic-decoder engine.
//   eng_state_t       : engine control states
//   VALUE_W, RANGE_W  : default widths of m_value / m_range
//   RANGE_INIT        : m_range after slice initialisation
//   BITS_NEEDED_INIT  : bits_needed after slice initialisation (5-bit signed)
package cabac_pkg;

  localparam int unsigned VALUE_W = 16;
  localparam int unsigned RANGE_W = 9;

  localparam logic [RANGE_W-1:0] RANGE_INIT       = 9'd510;
  localparam logic signed [4:0]  BITS_NEEDED_INIT = -5'sd8;

  typedef enum logic [2:0] {
    IDLE,
    INIT_HI,
    INIT_LO,
    READY,
    REFILL
  } eng_state_t;

endpackage

// File: rtl/cabac_byte_merge.sv
// Combinational byte merge used by both the in-line refill (READY accept)
// and the stalled refill (REFILL exit).
//   value_i : m_value before the merge
//   byte_i  : incoming bitstream byte
//   sum_i   : bit position to insert the byte at (0..5 when used)
//   value_o : value_i + (byte_i << sum_i), modulo 2^VALUE_W
//   bits_o  : sum_i - 8, the new bits_needed
module cabac_byte_merge #(
  parameter int unsigned VALUE_W = 16
) (
  input  logic [VALUE_W-1:0] value_i,
  input  logic [7:0]         byte_i,
  input  logic signed [4:0]  sum_i,
  output logic [VALUE_W-1:0] value_o,
  output logic signed [4:0]  bits_o
);

  logic [VALUE_W-1:0] shifted;

  always_comb begin
    shifted = VALUE_W'(byte_i) << $unsigned(sum_i);
    value_o = value_i + shifted;
    bits_o  = sum_i - 5'sd8;
  end

endmodule

// File: rtl/cabac_engine_ctrl.sv
// CABAC arithmetic-decoder engine control. Holds m_range, m_value and the
// signed bits_needed counter, loads the first two slice bytes, presents the
// engine state to the combinational bin decoder and commits its result,
// refilling m_value from the byte stream once bits_needed reaches >= 0.
//   init_start                        : restart slice initialisation
//   byte_valid/byte_data/byte_ready   : bitstream byte handshake
//   bin_req_valid/pstate/ready        : regular-bin request handshake
//   dec_range/value/pstate            : state driven to the bin decoder
//   dec_range_in/value_in/numbits/bin/lps : bin decoder results
//   bin_valid/bin_out/bin_is_lps      : registered decoded bin
//   busy                              : engine not in READY
module cabac_engine_ctrl import cabac_pkg::*; #(
  parameter int unsigned VALUE_W = 16,
  parameter int unsigned RANGE_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  input  logic               bin_req_valid,
  input  logic [7:0]         bin_req_pstate,
  output logic               bin_req_ready,
  output logic [RANGE_W-1:0] dec_range,
  output logic [VALUE_W-1:0] dec_value,
  output logic [7:0]         dec_pstate,
  input  logic [RANGE_W-1:0] dec_range_in,
  input  logic [VALUE_W-1:0] dec_value_in,
  input  logic [2:0]         dec_numbits,
  input  logic [1:0]         dec_bin,
  input  logic               dec_lps,
  output logic               bin_valid,
  output logic               bin_out,
  output logic               bin_is_lps,
  output logic               busy
);

  eng_state_t         state_q, state_d;
  logic [RANGE_W-1:0] range_q, range_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic signed [4:0]  bits_q, bits_d;
  logic               bin_valid_q, bin_valid_d;
  logic               bin_out_q, bin_out_d;
  logic               bin_is_lps_q, bin_is_lps_d;

  logic signed [4:0]  sum;
  logic [VALUE_W-1:0] merge_value_in, merge_value_out;
  logic signed [4:0]  merge_sum, merge_bits;
  logic               unused_bin_hi;

  assign unused_bin_hi = dec_bin[1];

  // bits_needed is -8..-1 in READY and numbits is 0..6, so sum fits 5 bits.
  assign sum = bits_q + $signed({2'b00, dec_numbits});

  // In REFILL, bits_q holds the non-negative sum from the stalled accept.
  cabac_byte_merge #(.VALUE_W(VALUE_W)) u_merge (
    .value_i (merge_value_in),
    .byte_i  (byte_data),
    .sum_i   (merge_sum),
    .value_o (merge_value_out),
    .bits_o  (merge_bits)
  );

  always_comb begin
    state_d        = state_q;
    range_d        = range_q;
    value_d        = value_q;
    bits_d         = bits_q;
    bin_valid_d    = 1'b0;
    bin_out_d      = bin_out_q;
    bin_is_lps_d   = bin_is_lps_q;
    byte_ready     = 1'b0;
    bin_req_ready  = 1'b0;
    merge_value_in = value_q;
    merge_sum      = bits_q;

    if (init_start) begin
      state_d = INIT_HI;
    end else begin
      case (state_q)
        IDLE: ;
        INIT_HI: begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            value_d = VALUE_W'(byte_data);
            state_d = INIT_LO;
          end
        end
        INIT_LO: begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            value_d = VALUE_W'({value_q[7:0], byte_data});
            range_d = RANGE_W'(RANGE_INIT);
            bits_d  = BITS_NEEDED_INIT;
            state_d = READY;
          end
        end
        READY: begin
          bin_req_ready = 1'b1;
          if (bin_req_valid) begin
            bin_valid_d    = 1'b1;
            bin_out_d      = dec_bin[0];
            bin_is_lps_d   = dec_lps;
            range_d        = dec_range_in;
            merge_value_in = dec_value_in;
            merge_sum      = sum;
            if (sum[4]) begin
              value_d = dec_value_in;
              bits_d  = sum;
            end else begin
              byte_ready = 1'b1;
              if (byte_valid) begin
                value_d = merge_value_out;
                bits_d  = merge_bits;
              end else begin
                value_d = dec_value_in;
                bits_d  = sum;
                state_d = REFILL;
              end
            end
          end
        end
        REFILL: begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            value_d = merge_value_out;
            bits_d  = merge_bits;
            state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      range_q      <= RANGE_W'(RANGE_INIT);
      value_q      <= '0;
      bits_q       <= BITS_NEEDED_INIT;
      bin_valid_q  <= 1'b0;
      bin_out_q    <= 1'b0;
      bin_is_lps_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      range_q      <= range_d;
      value_q      <= value_d;
      bits_q       <= bits_d;
      bin_valid_q  <= bin_valid_d;
      bin_out_q    <= bin_out_d;
      bin_is_lps_q <= bin_is_lps_d;
    end
  end

  assign dec_range  = range_q;
  assign dec_value  = value_q;
  assign dec_pstate = bin_req_pstate;
  assign bin_valid  = bin_valid_q;
  assign bin_out    = bin_out_q;
  assign bin_is_lps = bin_is_lps_q;
  assign busy       = (state_q != READY);

endmodule

// File: tb/tb_cabac_engine_ctrl.sv
// Bench for cabac_engine_ctrl. The bin decoder is replaced by directly driven
// stub values; expected bins are queued at issue time and checked by a
// separate monitor whenever bin_valid is seen.
module tb_cabac_engine_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        bin_req_valid;
  logic [7:0]  bin_req_pstate;
  logic        bin_req_ready;
  logic [8:0]  dec_range;
  logic [15:0] dec_value;
  logic [7:0]  dec_pstate;
  logic [8:0]  dec_range_in;
  logic [15:0] dec_value_in;
  logic [2:0]  dec_numbits;
  logic [1:0]  dec_bin;
  logic        dec_lps;
  logic        bin_valid;
  logic        bin_out;
  logic        bin_is_lps;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        bin;
    logic        lps;
    logic [15:0] value;
    logic [8:0]  range;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cabac_engine_ctrl #(.VALUE_W(16), .RANGE_W(9)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init_start     (init_start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .bin_req_valid  (bin_req_valid),
    .bin_req_pstate (bin_req_pstate),
    .bin_req_ready  (bin_req_ready),
    .dec_range      (dec_range),
    .dec_value      (dec_value),
    .dec_pstate     (dec_pstate),
    .dec_range_in   (dec_range_in),
    .dec_value_in   (dec_value_in),
    .dec_numbits    (dec_numbits),
    .dec_bin        (dec_bin),
    .dec_lps        (dec_lps),
    .bin_valid      (bin_valid),
    .bin_out        (bin_out),
    .bin_is_lps     (bin_is_lps),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    init_start    = 1'b0;
    bin_req_valid = 1'b0;
    byte_valid    = 1'b0;
  endtask

  task automatic quiet();
    @(negedge clk);
    idle();
  endtask

  // init_start (optionally with a competing request and a decoy byte), then b0, b1.
  task automatic init_seq(input logic [7:0] b0, input logic [7:0] b1, input logic with_req);
    @(negedge clk);
    idle();
    init_start    = 1'b1;
    bin_req_valid = with_req;
    byte_valid    = 1'b1;
    byte_data     = 8'hEE;
    #1;
    check("init_req_ready", bin_req_ready, 1'b0);
    check("init_byte_ready", byte_ready, 1'b0);
    @(negedge clk);
    init_start    = 1'b0;
    bin_req_valid = 1'b0;
    byte_data     = b0;
    #1;
    check("init_hi_byte_ready", byte_ready, 1'b1);
    check("init_hi_busy", busy, 1'b1);
    @(negedge clk);
    byte_data = b1;
    #1;
    check("init_lo_byte_ready", byte_ready, 1'b1);
    @(negedge clk);
    byte_valid = 1'b0;
    #1;
    check("init_done_busy", busy, 1'b0);
    check("init_value", dec_value, {16'h0, b0, b1});
    check("init_range", dec_range, 9'd510);
    check("init_req_ready_ready", bin_req_ready, 1'b1);
  endtask

  // Presents one request (left asserted); the next task call replaces or drops it.
  task automatic req(input logic [2:0] nb, input logic [15:0] vin, input logic [8:0] rin,
                     input logic [1:0] b, input logic lps, input logic bv, input logic [7:0] bd,
                     input logic exp_br, input logic [15:0] exp_val);
    exp_t e;
    @(negedge clk);
    init_start    = 1'b0;
    bin_req_valid = 1'b1;
    dec_numbits   = nb;
    dec_value_in  = vin;
    dec_range_in  = rin;
    dec_bin       = b;
    dec_lps       = lps;
    byte_valid    = bv;
    byte_data     = bd;
    #1;
    check("req_ready", bin_req_ready, 1'b1);
    check("accept_byte_ready", byte_ready, exp_br);
    e.bin   = b[0];
    e.lps   = lps;
    e.value = exp_val;
    e.range = rin;
    sb.push_back(e);
  endtask

  // Monitor: every bin_valid cycle must match the oldest queued expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && bin_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bin: got bin_valid=1 expected no pending bin at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("bin_out", bin_out, e.bin);
          check("bin_is_lps", bin_is_lps, e.lps);
          check("commit_value", dec_value, e.value);
          check("commit_range", dec_range, e.range);
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    idle();
    byte_data      = 8'h00;
    bin_req_pstate = 8'h00;
    dec_range_in   = '0;
    dec_value_in   = '0;
    dec_numbits    = '0;
    dec_bin        = '0;
    dec_lps        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_bin_valid", bin_valid, 1'b0);
    check("rst_bin_out", bin_out, 1'b0);
    check("rst_lps", bin_is_lps, 1'b0);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_req_ready", bin_req_ready, 1'b0);
    check("rst_range", dec_range, 9'd510);
    check("rst_value", dec_value, 16'h0000);
    rst_n = 1'b1;

    // IDLE ignores bytes and requests; pstate is a pure pass-through.
    @(negedge clk);
    byte_valid     = 1'b1;
    bin_req_valid  = 1'b1;
    bin_req_pstate = 8'h5A;
    #1;
    check("idle_byte_ready", byte_ready, 1'b0);
    check("idle_req_ready", bin_req_ready, 1'b0);
    check("pstate_pass", dec_pstate, 8'h5A);
    quiet();

    // Scenario 1: basic init and a no-refill bin, then refill at sum==0.
    init_seq(8'h12, 8'h34, 1'b0);
    req(3'd2, 16'h48D0, 9'h1F0, 2'b01, 1'b0, 1'b1, 8'hFF, 1'b0, 16'h48D0);      // bits -6
    quiet();
    #1;
    check("s1_value", dec_value, 16'h48D0);
    check("s1_range", dec_range, 9'h1F0);
    req(3'd5, 16'h1111, 9'h100, 2'b10, 1'b1, 1'b1, 8'h00, 1'b0, 16'h1111);      // bits -1, bin 0
    req(3'd1, 16'h4000, 9'h150, 2'b01, 1'b1, 1'b1, 8'h80, 1'b1, 16'h4080);      // sum 0, bits -8
    req(3'd0, 16'h4080, 9'h150, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 16'h4080);      // bits -8
    quiet();

    // Scenario 3: in-line refill with byte available, no stall.
    init_seq(8'h12, 8'h34, 1'b0);
    req(3'd6, 16'h1000, 9'h1A0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 16'h1000);      // bits -2
    req(3'd3, 16'h2000, 9'h1C0, 2'b00, 1'b1, 1'b1, 8'hAB, 1'b1, 16'h2156);      // bits -7
    req(3'd6, 16'h3000, 9'h100, 2'b01, 1'b0, 1'b1, 8'h77, 1'b0, 16'h3000);      // sum -1
    quiet();

    // Scenario 4: refill stalls for 3 cycles, then completes.
    init_seq(8'h12, 8'h34, 1'b0);
    req(3'd6, 16'h1000, 9'h1A0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 16'h1000);
    req(3'd3, 16'h2000, 9'h1C0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b1, 16'h2000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bin_req_valid = 1'b1;
      byte_valid    = 1'b0;
      #1;
      check("stall_req_ready", bin_req_ready, 1'b0);
      check("stall_busy", busy, 1'b1);
      check("stall_byte_ready", byte_ready, 1'b1);
    end
    @(negedge clk);
    bin_req_valid = 1'b0;
    byte_valid    = 1'b1;
    byte_data     = 8'hAB;
    #1;
    check("refill_byte_ready", byte_ready, 1'b1);
    check("refill_hold_value", dec_value, 16'h2000);
    quiet();
    #1;
    check("refill_busy", busy, 1'b0);
    check("refill_value", dec_value, 16'h2156);
    req(3'd6, 16'h3000, 9'h100, 2'b01, 1'b0, 1'b1, 8'h77, 1'b0, 16'h3000);      // bits was -7
    quiet();

    // Scenario 5: init_start during REFILL with a competing request.
    init_seq(8'h12, 8'h34, 1'b0);
    req(3'd6, 16'h1000, 9'h1A0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 16'h1000);
    req(3'd3, 16'h2000, 9'h1C0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 16'h2000);
    init_seq(8'h56, 8'h78, 1'b1);
    req(3'd6, 16'h0100, 9'h1FE, 2'b00, 1'b0, 1'b1, 8'h99, 1'b0, 16'h0100);      // fresh bits -8
    quiet();

    // Scenario 6: asynchronous reset while stalled in REFILL with bin_out=1.
    req(3'd3, 16'h2000, 9'h1C0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b1, 16'h2000);      // bits -2 -> sum 1
    quiet();
    byte_valid    = 1'b1;
    bin_req_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b1);
    check("arst_bin_valid", bin_valid, 1'b0);
    check("arst_bin_out", bin_out, 1'b0);
    check("arst_lps", bin_is_lps, 1'b0);
    check("arst_byte_ready", byte_ready, 1'b0);
    check("arst_req_ready", bin_req_ready, 1'b0);
    check("arst_range", dec_range, 9'd510);
    check("arst_value", dec_value, 16'h0000);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    init_seq(8'hCA, 8'hFE, 1'b0);
    quiet();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
